// File: rtl/cpu_pkg.sv
// Shared CPU definitions: sequencer state encoding and instruction opcodes.
package cpu_pkg;

  typedef enum logic [3:0] {
    S0     = 4'd0,
    S1     = 4'd1,
    S2     = 4'd2,
    S3     = 4'd3,
    S4     = 4'd4,
    S5     = 4'd5,
    S6     = 4'd6,
    S7     = 4'd7,
    HALTED = 4'd8
  } state_e;

  localparam logic [2:0] OP_HLT  = 3'd0;
  localparam logic [2:0] OP_SKZ  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_ANDD = 3'd3;
  localparam logic [2:0] OP_XORR = 3'd4;
  localparam logic [2:0] OP_LDA  = 3'd5;
  localparam logic [2:0] OP_STO  = 3'd6;
  localparam logic [2:0] OP_JMP  = 3'd7;

endpackage

// File: rtl/instr_sequencer.sv
// Eight-phase instruction sequencer: fetches a two-byte instruction, then
// issues memory/PC/accumulator strobes decoded from the latched opcode.
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int OPW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ena,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           rd,
  output logic           wr,
  output logic           load_ir,
  output logic           inc_pc,
  output logic           load_pc,
  output logic           load_acc,
  output logic           datactl_ena,
  output logic           halt,
  output logic [3:0]     state_o
);

  state_e         state;
  state_e         state_nxt;
  logic [OPW-1:0] op_q;
  logic           zero_q;

  logic op_hlt, op_skz, op_sto, op_jmp, op_alu;

  assign op_hlt = (op_q == OPW'(OP_HLT));
  assign op_skz = (op_q == OPW'(OP_SKZ));
  assign op_sto = (op_q == OPW'(OP_STO));
  assign op_jmp = (op_q == OPW'(OP_JMP));
  assign op_alu = (op_q == OPW'(OP_ADD))  || (op_q == OPW'(OP_ANDD)) ||
                  (op_q == OPW'(OP_XORR)) || (op_q == OPW'(OP_LDA));

  assign state_o = state;

  // Opcode is sampled only leaving S2 and the zero flag only leaving S3, so
  // later bus activity cannot disturb the instruction in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S0;
      op_q   <= '0;
      zero_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S2) op_q   <= opcode;
      if (state == S3) zero_q <= zero;
    end
  end

  always_comb begin
    state_nxt   = state;
    rd          = 1'b0;
    wr          = 1'b0;
    load_ir     = 1'b0;
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    load_acc    = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    case (state)
      S0: begin
        if (ena) begin
          rd        = 1'b1;
          load_ir   = 1'b1;
          inc_pc    = 1'b1;
          state_nxt = S1;
        end
      end
      S1: begin
        rd        = 1'b1;
        load_ir   = 1'b1;
        inc_pc    = 1'b1;
        state_nxt = S2;
      end
      S2: state_nxt = S3;
      S3: state_nxt = op_hlt ? HALTED : S4;
      S4: begin
        rd          = op_alu;
        datactl_ena = op_sto;
        load_pc     = op_jmp;
        inc_pc      = op_skz & zero_q;
        state_nxt   = S5;
      end
      S5: begin
        rd          = op_alu;
        load_acc    = op_alu;
        wr          = op_sto;
        datactl_ena = op_sto;
        load_pc     = op_jmp;
        state_nxt   = S6;
      end
      S6: begin
        datactl_ena = op_sto;
        inc_pc      = op_skz & zero_q;
        state_nxt   = S7;
      end
      S7:      state_nxt = S0;
      HALTED:  halt      = 1'b1;
      default: state_nxt = S0;
    endcase
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter OPW, default 3, meaning opcode field width.
REQ-002 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port ena  input  1  run enable from machine_ctrl.
REQ-005 SHALL have port opcode  input  OPW  instruction register opcode field.
REQ-006 SHALL have port zero  input  1  accumulator-is-zero flag.
REQ-007 SHALL have port rd  output  1  memory read strobe.
REQ-008 SHALL have port wr  output  1  memory write strobe.
REQ-009 SHALL have port load_ir  output  1  instruction register load.
REQ-010 SHALL have port inc_pc  output  1  PC increment by one byte.
REQ-011 SHALL have port load_pc  output  1  PC load from IR address field.
REQ-012 SHALL have port load_acc  output  1  accumulator load.
REQ-013 SHALL have port datactl_ena  output  1  drive accumulator onto data bus.
REQ-014 SHALL have port halt  output  1  CPU halted.
REQ-015 SHALL have port state_o  output  4  current state, debug only.

Function
REQ-016 SHALL use opcodes HLT=0, SKZ=1, ADD=2, ANDD=3, XORR=4, LDA=5, STO=6, JMP=7; ALU class = ADD/ANDD/XORR/LDA.
REQ-017 SHALL sequence states S0..S7 and HALTED, one clk per state; S7->S0 unconditional.
REQ-018 SHALL hold in S0 with all strobes 0 while ena=0; S0->S1 only when ena=1.
REQ-019 SHALL, once S1 entered, complete the instruction through S7 regardless of ena.
REQ-020 SHALL assert rd, load_ir, inc_pc in S0 (ena=1) and in S1 (two-byte fetch).
REQ-021 SHALL assert no strobe in S2; SHALL capture opcode into op_q on the S2->S3 edge.
REQ-022 SHALL, in S3, capture zero into zero_q; if op_q=HLT go to HALTED, else S4.
REQ-023 SHALL, in S4: ALU -> rd; STO -> datactl_ena; JMP -> load_pc; SKZ -> inc_pc=zero_q.
REQ-024 SHALL, in S5: ALU -> rd, load_acc; STO -> wr, datactl_ena; JMP -> load_pc.
REQ-025 SHALL, in S6: STO -> datactl_ena; SKZ -> inc_pc=zero_q.
REQ-026 SHALL assert no strobe in S7, nor in any state/opcode pair not listed.
REQ-027 SHALL, in HALTED, assert halt=1, all other strobes 0, and remain until rst.
REQ-028 SHALL never assert rd and wr together, nor load_pc and inc_pc together.
REQ-029 SHALL decode strobes combinationally from state and op_q/zero_q only; opcode/zero changes outside their capture edges SHALL have no effect.

Reset
REQ-030 SHALL, on rst=1 at a rising edge, enter S0, clear op_q and zero_q, regardless of current state, including HALTED and mid-instruction.
REQ-031 SHALL drive all strobes and halt 0 and state_o=0 while in reset state with ena=0.
REQ-032 SHALL give rst priority over ena.

Structure
REQ-033 SHALL take opcode encodings and the state enumeration (S0..S7=0..7, HALTED=8) from shared package cpu_pkg.
REQ-034 SHALL be one module with no sub-module; state register, op_q, zero_q plus decode logic.

Verification
REQ-035 SHALL test: rst 2 cycles, ena=0 10 cycles -> state_o=0, all strobes 0 throughout.
REQ-036 SHALL test: ena=1, opcode=ADD -> rd in S0,S1,S4,S5; inc_pc in S0,S1; load_acc only in S5; 8 cycles per instruction.
REQ-037 SHALL test: opcode=STO -> wr only in S5; datactl_ena in S4,S5,S6; rd only in S0,S1.
REQ-038 SHALL test: SKZ with zero=1 at S3 then zero=0 -> inc_pc in S4 and S6 (4 total pulses); SKZ with zero=0 -> 2 total pulses.
REQ-039 SHALL test: opcode=JMP -> load_pc in S4,S5, no inc_pc after S1; opcode=HLT -> halt=1 from cycle after S3, held 20 cycles.
REQ-040 SHALL test: rst asserted in S5 of STO and in HALTED -> next cycle state_o=0, wr=0, halt=0.
